// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared types and constants for the period meter
package scope_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_RISE,
        MEASURE_LO,
        MEASURE_HI
    } state_t;

    localparam int DEF_DATA_W = 12;
    localparam int BCD_MAX    = 9999;

    // One double-dabble iteration: correct each BCD digit, then shift left.
    function automatic logic [29:0] dabble_step(input logic [29:0] s);
        logic [29:0] r;
        r = s;
        for (int d = 0; d < 4; d++) begin
            if (r[14+4*d +: 4] >= 4'd5) begin
                r[14+4*d +: 4] = r[14+4*d +: 4] + 4'd3;
            end
        end
        return {r[28:0], 1'b0};
    endfunction

endpackage

// File: rtl/period_meter_if.sv
// rtl/period_meter_if.sv - sample feed and result bundle of the period meter
interface period_meter_if
    import scope_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 20
);
    logic              enable;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [DATA_W-1:0] threshold;
    logic [CNT_W-1:0]  period_out;
    logic              period_valid;
    logic [15:0]       bcd_out;
    logic              bcd_valid;
    logic              no_signal;

    modport master (
        output enable, sample_valid, sample_data, threshold,
        input  period_out, period_valid, bcd_out, bcd_valid, no_signal
    );

    modport slave (
        input  enable, sample_valid, sample_data, threshold,
        output period_out, period_valid, bcd_out, bcd_valid, no_signal
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 14-bit iterative double-dabble: 1 load cycle, 14 shift cycles
module bin2bcd_seq
    import scope_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);
    logic [29:0] sh_q, sh_d, sh_next;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] bcd_q, bcd_d;

    assign sh_next = dabble_step(sh_q);

    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        bcd_d  = bcd_q;
        if (start && !busy_q) begin
            sh_d   = {16'h0000, bin};
            cnt_d  = 4'd14;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sh_d  = sh_next;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                bcd_d  = sh_next[29:14];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            bcd_q  <= bcd_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - hysteretic rising-crossing period meter with averaged count and BCD readout
module period_meter
    import scope_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CNT_W    = 20,
    parameter int AVG_LOG2 = 2,
    parameter int HYST     = 16
) (
    input  logic          clock,
    input  logic          reset,
    period_meter_if.slave bus
);
    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int TAL_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [TAL_W-1:0]  TALLY_LAST = TAL_W'((1 << AVG_LOG2) - 1);
    localparam logic [DATA_W-1:0] HYST_V     = DATA_W'(HYST);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic [TAL_W-1:0]   tally_q, tally_d;
    logic [CNT_W-1:0]   period_q, period_d, period_now;
    logic               pvalid_q, pvalid_d;
    logic               nosig_q, nosig_d;
    logic               start_q, start_d;
    logic [13:0]        start_bin_q, start_bin_d;
    logic               pend_q, pend_d;
    logic [13:0]        pend_bin_q, pend_bin_d;
    logic [DATA_W-1:0]  thr_lo;
    logic               below, above, bcd_busy, conv_busy;
    logic [13:0]        clip;

    assign thr_lo     = (bus.threshold > HYST_V) ? bus.threshold - HYST_V : '0;
    assign below      = bus.sample_data < thr_lo;
    assign above      = bus.sample_data >= bus.threshold;
    assign period_now = cnt_q + 1'b1;
    assign acc_sum    = acc_q + ACC_W'(period_now);
    assign clip       = (32'(period_q) > BCD_MAX) ? 14'(BCD_MAX) : 14'(period_q);
    assign conv_busy  = start_q | bcd_busy;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        tally_d  = tally_q;
        period_d = period_q;
        pvalid_d = 1'b0;
        nosig_d  = nosig_q;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            tally_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    tally_d = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (bus.sample_valid && below) begin
                        cnt_d   = '0;
                        state_d = WAIT_RISE;
                    end
                end
                WAIT_RISE, MEASURE_LO, MEASURE_HI: begin
                    if (bus.sample_valid) begin
                        if (state_q != MEASURE_LO && above) begin
                            cnt_d   = '0;
                            state_d = MEASURE_LO;
                            if (state_q == MEASURE_HI) begin
                                if (tally_q == TALLY_LAST) begin
                                    period_d = CNT_W'(acc_sum >> AVG_LOG2);
                                    pvalid_d = 1'b1;
                                    nosig_d  = 1'b0;
                                    acc_d    = '0;
                                    tally_d  = '0;
                                end else begin
                                    acc_d   = acc_sum;
                                    tally_d = tally_q + 1'b1;
                                end
                            end
                        end else if (cnt_q == CNT_LAST) begin
                            // Counter would hit all-ones: report loss of signal and re-arm.
                            period_d = '0;
                            nosig_d  = 1'b1;
                            pvalid_d = 1'b1;
                            state_d  = ARM;
                            cnt_d    = '0;
                            acc_d    = '0;
                            tally_d  = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            if (state_q == MEASURE_LO && below) begin
                                state_d = MEASURE_HI;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // One pending slot: the newest result waits for the converter to go idle.
    always_comb begin
        start_d     = 1'b0;
        start_bin_d = start_bin_q;
        pend_d      = pend_q;
        pend_bin_d  = pend_bin_q;
        if (pend_q && !conv_busy) begin
            start_d     = 1'b1;
            start_bin_d = pend_bin_q;
            pend_d      = 1'b0;
        end
        if (pvalid_q) begin
            if (conv_busy || pend_q) begin
                pend_d     = 1'b1;
                pend_bin_d = clip;
            end else begin
                start_d     = 1'b1;
                start_bin_d = clip;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            tally_q     <= '0;
            period_q    <= '0;
            pvalid_q    <= 1'b0;
            nosig_q     <= 1'b1;
            start_q     <= 1'b0;
            start_bin_q <= '0;
            pend_q      <= 1'b0;
            pend_bin_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            tally_q     <= tally_d;
            period_q    <= period_d;
            pvalid_q    <= pvalid_d;
            nosig_q     <= nosig_d;
            start_q     <= start_d;
            start_bin_q <= start_bin_d;
            pend_q      <= pend_d;
            pend_bin_q  <= pend_bin_d;
        end
    end

    bin2bcd_seq u_bcd (
        .clock (clock),
        .reset (reset),
        .start (start_q),
        .bin   (start_bin_q),
        .busy  (bcd_busy),
        .done  (bus.bcd_valid),
        .bcd   (bus.bcd_out)
    );

    assign bus.period_out   = period_q;
    assign bus.period_valid = pvalid_q;
    assign bus.no_signal    = nosig_q;
endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - directed self-checking bench for period_meter
module tb_period_meter;
    import scope_pkg::*;

    logic        clock;
    logic        reset;
    logic        en_m, en_t, en_z, sv;
    logic [11:0] sd, thr;
    int          n_chk, n_fail;
    int          pv_m, bv_m, pv_t, pv_z;
    int          p0, b0, nb, t0, t1;
    logic [15:0] v0, v1;

    period_meter_if #(.DATA_W(12), .CNT_W(20)) if_m ();
    period_meter_if #(.DATA_W(12), .CNT_W(8))  if_t ();
    period_meter_if #(.DATA_W(12), .CNT_W(20)) if_z ();

    assign if_m.enable = en_m;  assign if_m.sample_valid = sv;
    assign if_m.sample_data = sd; assign if_m.threshold = thr;
    assign if_t.enable = en_t;  assign if_t.sample_valid = sv;
    assign if_t.sample_data = sd; assign if_t.threshold = thr;
    assign if_z.enable = en_z;  assign if_z.sample_valid = sv;
    assign if_z.sample_data = sd; assign if_z.threshold = thr;

    period_meter #(.DATA_W(12), .CNT_W(20), .AVG_LOG2(2), .HYST(16)) u_m (
        .clock(clock), .reset(reset), .bus(if_m));
    period_meter #(.DATA_W(12), .CNT_W(8), .AVG_LOG2(2), .HYST(16)) u_t (
        .clock(clock), .reset(reset), .bus(if_t));
    period_meter #(.DATA_W(12), .CNT_W(20), .AVG_LOG2(0), .HYST(16)) u_z (
        .clock(clock), .reset(reset), .bus(if_z));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        #2;
        if (if_m.period_valid) pv_m <= pv_m + 1;
        if (if_m.bcd_valid)    bv_m <= bv_m + 1;
        if (if_t.period_valid) pv_t <= pv_t + 1;
        if (if_z.period_valid) pv_z <= pv_z + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic strobe(input logic [11:0] v);
        sv = 1'b1;
        sd = v;
        @(negedge clock);
        sv = 1'b0;
    endtask

    task automatic square(input int lo, input int hi, input int nper);
        for (int p = 0; p < nper; p++) begin
            repeat (lo) strobe(12'd0);
            repeat (hi) strobe(12'd4000);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        pv_m = 0; bv_m = 0; pv_t = 0; pv_z = 0;
        reset = 1'b1; en_m = 1'b0; en_t = 1'b0; en_z = 1'b0;
        sv = 1'b0; sd = '0; thr = 12'd2048;
        idle(3);
        reset = 1'b0;
        idle(100);
        check_eq("rst_period", 32'(if_m.period_out), 0);
        check_eq("rst_bcd", 32'(if_m.bcd_out), 0);
        check_eq("rst_nosig", 32'(if_m.no_signal), 1);
        check_eq("rst_pulses", pv_m + bv_m + pv_t + pv_z, 0);

        // 20-sample square wave, result after the fifth rising crossing
        en_m = 1'b1; en_t = 1'b1;
        idle(1);
        square(10, 10, 4);
        repeat (10) strobe(12'd0);
        check_eq("sq_early", pv_m, 0);
        strobe(12'd4000);
        check_eq("sq_pv", 32'(if_m.period_valid), 1);
        check_eq("sq_period", 32'(if_m.period_out), 20);
        check_eq("sq_nosig", 32'(if_m.no_signal), 0);
        check_eq("sq_t_period", 32'(if_t.period_out), 20);
        idle(15);
        check_eq("sq_bcd_early", 32'(if_m.bcd_valid), 0);
        idle(1);
        check_eq("sq_bcd_valid", 32'(if_m.bcd_valid), 1);
        check_eq("sq_bcd", 32'(if_m.bcd_out), 32'h0020);

        // Timeout on the 8-bit counter instance
        en_m = 1'b0; en_t = 1'b0;
        idle(2);
        en_t = 1'b1;
        idle(1);
        strobe(12'd0);
        strobe(12'd4000);
        p0 = pv_t;
        repeat (254) strobe(12'd0);
        check_eq("to_early", pv_t - p0, 0);
        strobe(12'd0);
        check_eq("to_pv", 32'(if_t.period_valid), 1);
        check_eq("to_period", 32'(if_t.period_out), 0);
        check_eq("to_nosig", 32'(if_t.no_signal), 1);
        idle(3);
        check_eq("to_once", pv_t - p0, 1);
        en_t = 1'b0;

        // Chatter inside the hysteresis band with a genuine swing every 50 strobes
        en_m = 1'b1;
        idle(1);
        p0 = pv_m; b0 = bv_m;
        repeat (5) strobe(12'd0);
        for (int p = 0; p < 5; p++) begin
            strobe(12'd4000);
            for (int i = 0; i < 44; i++) strobe((i % 2) != 0 ? 12'd2040 : 12'd2050);
            repeat (5) strobe(12'd0);
        end
        check_eq("ch_pulses", pv_m - p0, 1);
        check_eq("ch_period", 32'(if_m.period_out), 50);
        check_eq("ch_bcd_pulses", bv_m - b0, 1);
        check_eq("ch_bcd", 32'(if_m.bcd_out), 32'h0050);

        // Enable dropped mid-measurement needs four fresh periods
        en_m = 1'b0;
        idle(2);
        en_m = 1'b1;
        idle(1);
        square(15, 15, 3);
        repeat (5) strobe(12'd0);
        en_m = 1'b0;
        idle(1);
        en_m = 1'b1;
        idle(1);
        p0 = pv_m;
        square(15, 15, 4);
        repeat (15) strobe(12'd0);
        check_eq("ab_early", pv_m - p0, 0);
        strobe(12'd4000);
        check_eq("ab_pv", 32'(if_m.period_valid), 1);
        check_eq("ab_period", 32'(if_m.period_out), 30);

        // Reset in the middle of the conversion
        idle(5);
        b0 = bv_m;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        en_m = 1'b0;
        idle(30);
        check_eq("rc_bcd_pulses", bv_m - b0, 0);
        check_eq("rc_bcd", 32'(if_m.bcd_out), 0);
        check_eq("rc_period", 32'(if_m.period_out), 0);
        check_eq("rc_nosig", 32'(if_m.no_signal), 1);

        // Saturation above 9999 on the unaveraged instance
        en_z = 1'b1;
        idle(1);
        strobe(12'd0);
        strobe(12'd4000);
        repeat (12344) strobe(12'd0);
        strobe(12'd4000);
        check_eq("sat_pv", 32'(if_z.period_valid), 1);
        check_eq("sat_period", 32'(if_z.period_out), 12345);
        idle(16);
        check_eq("sat_bcd_valid", 32'(if_z.bcd_valid), 1);
        check_eq("sat_bcd", 32'(if_z.bcd_out), 32'h9999);

        // Two results 3 cycles apart: second waits in the pending slot
        en_z = 1'b0;
        idle(2);
        en_z = 1'b1;
        idle(1);
        strobe(12'd0);
        strobe(12'd4000);
        repeat (6) strobe(12'd0);
        strobe(12'd4000);
        check_eq("pd_period1", 32'(if_z.period_out), 7);
        strobe(12'd0);
        strobe(12'd0);
        strobe(12'd4000);
        check_eq("pd_pv2", 32'(if_z.period_valid), 1);
        check_eq("pd_period2", 32'(if_z.period_out), 3);
        nb = 0; t0 = 0; t1 = 0; v0 = '0; v1 = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (if_z.bcd_valid) begin
                if (nb == 0) begin
                    v0 = if_z.bcd_out; t0 = i;
                end else begin
                    v1 = if_z.bcd_out; t1 = i;
                end
                nb++;
            end
        end
        check_eq("pd_count", nb, 2);
        check_eq("pd_bcd1", 32'(v0), 32'h0007);
        check_eq("pd_time1", t0, 13);
        check_eq("pd_bcd2", 32'(v1), 32'h0003);
        check_eq("pd_time2", t1, 29);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
